// File: rtl/adventure_game_pkg.sv
// rtl/adventure_game_pkg.sv - room encoding, 7-seg digit patterns and the room move function
package adventure_game_pkg;

  typedef enum logic [2:0] {
    CAVE    = 3'd0,
    TUNNEL  = 3'd1,
    RIVER   = 3'd2,
    STASH   = 3'd3,
    DEN     = 3'd4,
    VICTORY = 3'd5,
    GRAVE   = 3'd6
  } room_t;

  // Segment order {a,b,c,d,e,f,g}, active-high
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  // Directions are tried in n>s>e>w order; one that leads nowhere from this room is skipped.
  function automatic room_t next_room(input room_t r, input logic n, input logic s,
                                      input logic e, input logic w);
    room_t nr;
    nr = r;
    case (r)
      CAVE:   if (e) nr = TUNNEL;
      TUNNEL: begin
        if (s)      nr = RIVER;
        else if (w) nr = CAVE;
      end
      RIVER: begin
        if (n)      nr = TUNNEL;
        else if (e) nr = DEN;
        else if (w) nr = STASH;
      end
      STASH:  if (e) nr = RIVER;
      default: nr = r;
    endcase
    return nr;
  endfunction

endpackage

// File: rtl/adventure_game_ctrl_hex_to_7seg.sv
// rtl/adventure_game_ctrl_hex_to_7seg.sv - combinational hex digit to 7-seg decoder
module hex_to_7seg
  import adventure_game_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/adventure_game_ctrl.sv
// rtl/adventure_game_ctrl.sv - adventure game top: room FSM, sword inventory, dragon, lives
module adventure_game_ctrl
  import adventure_game_pkg::*;
#(
  parameter int LIVES          = 1,
  parameter int DRAGON_HP      = 1,
  parameter int SWORD_MAX      = 1,
  parameter int RESPAWN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       n,
  input  logic       s,
  input  logic       e,
  input  logic       w,
  output logic       win,
  output logic       d,
  output logic [6:0] seg,
  output logic [2:0] room,
  output logic [3:0] lives_left
);

  localparam int SW = $clog2(SWORD_MAX + 1);
  localparam int RW = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
  localparam logic [SW-1:0] SWORD_TOP    = SW'(SWORD_MAX);
  localparam logic [RW-1:0] RESPAWN_LAST = RW'(RESPAWN_CYCLES - 1);

  room_t         cur_room;
  room_t         move_room;
  logic [SW-1:0] swords;
  logic [3:0]    dragon_hp;
  logic [RW-1:0] respawn_cnt;
  logic [3:0]    sword_hex;
  logic [6:0]    seg_dec;

  assign room      = cur_room;
  assign move_room = next_room(cur_room, n, s, e, w);
  assign sword_hex = 4'(swords);

  hex_to_7seg u_hex (
    .hex (sword_hex),
    .seg (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_room    <= CAVE;
      swords      <= '0;
      dragon_hp   <= 4'(DRAGON_HP);
      lives_left  <= 4'(LIVES);
      respawn_cnt <= '0;
      win         <= 1'b0;
      d           <= 1'b0;
      seg         <= SEG_0;
    end else begin
      seg <= seg_dec;
      case (cur_room)
        DEN: begin
          if (swords == '0) begin
            cur_room <= GRAVE;
            d        <= 1'b1;
          end else begin
            swords    <= swords - 1'b1;
            dragon_hp <= dragon_hp - 4'd1;
            if (dragon_hp == 4'd1) begin
              cur_room <= VICTORY;
              win      <= 1'b1;
            end
          end
        end
        GRAVE: begin
          // The last life never respawns; the grave holds until reset.
          if (lives_left > 4'd1) begin
            if (respawn_cnt == RESPAWN_LAST) begin
              cur_room    <= CAVE;
              lives_left  <= lives_left - 4'd1;
              swords      <= '0;
              respawn_cnt <= '0;
              d           <= 1'b0;
            end else begin
              respawn_cnt <= respawn_cnt + 1'b1;
            end
          end
        end
        VICTORY: ;
        default: begin
          cur_room <= move_room;
          if (move_room == STASH && cur_room != STASH && swords != SWORD_TOP)
            swords <= swords + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adventure_game_ctrl.sv
// tb/tb_adventure_game_ctrl.sv - directed vector bench for adventure_game_ctrl
module tb_adventure_game_ctrl;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;

  logic clk = 1'b0;
  logic reset, n, s, e, w;

  logic       win_v   [4];
  logic       d_v     [4];
  logic [6:0] seg_v   [4];
  logic [2:0] room_v  [4];
  logic [3:0] lives_v [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: two lives, 2: two swords vs two-hit dragon, 3: three lives, two-hit dragon
  adventure_game_ctrl u_dut0 (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
    .win(win_v[0]), .d(d_v[0]), .seg(seg_v[0]), .room(room_v[0]), .lives_left(lives_v[0]));
  adventure_game_ctrl #(.LIVES(2), .RESPAWN_CYCLES(4)) u_dut1 (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
    .win(win_v[1]), .d(d_v[1]), .seg(seg_v[1]), .room(room_v[1]), .lives_left(lives_v[1]));
  adventure_game_ctrl #(.SWORD_MAX(2), .DRAGON_HP(2)) u_dut2 (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
    .win(win_v[2]), .d(d_v[2]), .seg(seg_v[2]), .room(room_v[2]), .lives_left(lives_v[2]));
  adventure_game_ctrl #(.LIVES(3), .DRAGON_HP(2)) u_dut3 (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
    .win(win_v[3]), .d(d_v[3]), .seg(seg_v[3]), .room(room_v[3]), .lives_left(lives_v[3]));

  typedef struct {
    logic       rst;
    logic [3:0] nsew;
    logic [2:0] room;
    logic       win;
    logic       dd;
    logic [6:0] seg;
    logic [3:0] lives;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input int rst, input logic [3:0] nsew, input int rm,
                              input int wn, input int dd, input logic [6:0] sg, input int lv);
    vec_t v;
    v.rst = (rst != 0);
    v.nsew = nsew;
    v.room = 3'(rm);
    v.win = (wn != 0);
    v.dd = (dd != 0);
    v.seg = sg;
    v.lives = 4'(lv);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs for one clock, then let outputs settle past the edge
  task automatic step(input logic rst, input logic [3:0] nsew);
    reset = rst;
    {n, s, e, w} = nsew;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input int k, input string tag, input int rm, input int wn,
                            input int dd, input logic [6:0] sg, input int lv);
    chk({tag, ".room"}, int'(room_v[k]), rm);
    chk({tag, ".win"}, int'(win_v[k]), wn);
    chk({tag, ".d"}, int'(d_v[k]), dd);
    chk({tag, ".seg"}, int'(seg_v[k]), int'(sg));
    chk({tag, ".lives"}, int'(lives_v[k]), lv);
  endtask

  localparam logic [3:0] NO = 4'b0000, DN = 4'b1000, DS = 4'b0100, DE = 4'b0010, DW = 4'b0001;

  initial begin
    int grave_cycles;
    reset = 1'b1;
    {n, s, e, w} = 4'b0000;

    // default game: victory path, priority and invalid moves, then death
    vecs[0]  = mk(1, NO, 0, 0, 0, S0, 1);
    vecs[1]  = mk(0, DE, 1, 0, 0, S0, 1);
    vecs[2]  = mk(0, DS, 2, 0, 0, S0, 1);
    vecs[3]  = mk(0, DW, 3, 0, 0, S0, 1);
    vecs[4]  = mk(0, DE, 2, 0, 0, S1, 1);
    vecs[5]  = mk(0, DE, 4, 0, 0, S1, 1);
    vecs[6]  = mk(0, NO, 5, 1, 0, S1, 1);
    vecs[7]  = mk(0, NO, 5, 1, 0, S0, 1);
    vecs[8]  = mk(0, DW, 5, 1, 0, S0, 1);
    vecs[9]  = mk(1, DE, 0, 0, 0, S0, 1);
    vecs[10] = mk(0, DE, 1, 0, 0, S0, 1);
    vecs[11] = mk(0, DS, 2, 0, 0, S0, 1);
    vecs[12] = mk(0, DN | DE, 1, 0, 0, S0, 1);
    vecs[13] = mk(0, DW, 0, 0, 0, S0, 1);
    vecs[14] = mk(0, DW, 0, 0, 0, S0, 1);
    vecs[15] = mk(0, DN | DS, 0, 0, 0, S0, 1);
    vecs[16] = mk(0, DE, 1, 0, 0, S0, 1);
    vecs[17] = mk(0, DS, 2, 0, 0, S0, 1);
    vecs[18] = mk(0, DE | DW, 4, 0, 0, S0, 1);
    vecs[19] = mk(0, DW, 6, 0, 1, S0, 1);
    vecs[20] = mk(0, NO, 6, 0, 1, S0, 1);
    vecs[21] = mk(0, DN, 6, 0, 1, S0, 1);

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].rst, vecs[i].nsew);
      expect_all(0, $sformatf("vec%0d", i), int'(vecs[i].room), int'(vecs[i].win),
                 int'(vecs[i].dd), vecs[i].seg, int'(vecs[i].lives));
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'(i));
      chk($sformatf("grave_hold%0d.room", i), int'(room_v[0]), 6);
      chk($sformatf("grave_hold%0d.d", i), int'(d_v[0]), 1);
    end

    // two lives: timed respawn, then the second death is final
    step(1'b1, NO);
    expect_all(1, "lives2_reset", 0, 0, 0, S0, 2);
    step(1'b0, DE); step(1'b0, DS); step(1'b0, DE);
    chk("lives2_den", int'(room_v[1]), 4);
    step(1'b0, NO);
    expect_all(1, "lives2_grave", 6, 0, 1, S0, 2);
    grave_cycles = 1;
    for (int i = 0; i < 20 && room_v[1] == 3'd6; i++) begin
      step(1'b0, NO);
      if (d_v[1]) grave_cycles++;
    end
    chk("lives2_grave_cycles", grave_cycles, 4);
    expect_all(1, "lives2_respawn", 0, 0, 0, S0, 1);
    step(1'b0, DE); step(1'b0, DS); step(1'b0, DE); step(1'b0, NO);
    expect_all(1, "lives2_final_grave", 6, 0, 1, S0, 1);
    for (int i = 0; i < 6; i++) step(1'b0, DE);
    expect_all(1, "lives2_terminal", 6, 0, 1, S0, 1);

    // two-sword inventory saturates, two-hit dragon
    step(1'b1, NO);
    step(1'b0, DE); step(1'b0, DS);
    step(1'b0, DW); step(1'b0, DE);
    step(1'b0, DW); step(1'b0, DE);
    chk("sword2_seg_two", int'(seg_v[2]), int'(S2));
    step(1'b0, DW);
    step(1'b0, DW);
    chk("sword2_stay_stash", int'(room_v[2]), 3);
    step(1'b0, DE);
    chk("sword2_saturated", int'(seg_v[2]), int'(S2));
    step(1'b0, DE);
    chk("sword2_den", int'(room_v[2]), 4);
    step(1'b0, NO);
    expect_all(2, "sword2_hit1", 4, 0, 0, S2, 1);
    step(1'b0, NO);
    expect_all(2, "sword2_victory", 5, 1, 0, S1, 1);
    step(1'b0, NO);
    chk("sword2_seg_zero", int'(seg_v[2]), int'(S0));

    // reset during respawn restores lives and dragon hit points
    step(1'b1, NO);
    step(1'b0, DE); step(1'b0, DS); step(1'b0, DW); step(1'b0, DE); step(1'b0, DE);
    chk("rst_resp_den", int'(room_v[3]), 4);
    step(1'b0, NO);
    chk("rst_resp_hit", int'(room_v[3]), 4);
    step(1'b0, NO);
    expect_all(3, "rst_resp_grave1", 6, 0, 1, S0, 3);
    step(1'b0, NO);
    chk("rst_resp_grave2", int'(room_v[3]), 6);
    step(1'b1, DE);
    expect_all(3, "rst_resp_reset", 0, 0, 0, S0, 3);
    step(1'b0, DE); step(1'b0, DS); step(1'b0, DW); step(1'b0, DE); step(1'b0, DE);
    step(1'b0, NO);
    chk("rst_resp_hp_restored", int'(room_v[3]), 4);
    step(1'b0, NO);
    expect_all(3, "rst_resp_regrave", 6, 0, 1, S0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
